// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and default sizing for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    DRAIN
  } arb_state_t;

  localparam int UART_DATA_WIDTH        = 8;
  localparam int DEFAULT_NUM_REQ        = 4;
  localparam int DEFAULT_MAX_BURST      = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin pick, searching upward from rr_ptr+1
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // One extra bit on the sum so the wrap works for non-power-of-two NUM_REQ.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART TX port
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int MAX_BURST      = DEFAULT_MAX_BURST,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_last_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          valid_tx_out,
  output logic [DATA_WIDTH-1:0]         data_tx_out,
  input  logic                          ready_tx_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic                          timeout_out
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [BURST_W-1:0]  burst_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic [DATA_WIDTH-1:0] own_data;
  logic                own_valid;
  logic                own_last;
  logic                out_free;
  logic                own_accept;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid_in),
    .rr_ptr     (rr_ptr),
    .winner     (pick),
    .winner_idx (pick_idx)
  );

  // Output register can take a byte when empty or being drained this cycle.
  assign out_free   = !valid_tx_out || ready_tx_in;
  assign own_valid  = |(req_valid_in & grant_out);
  assign own_last   = |(req_last_in & grant_out);
  assign own_accept = (state == LOCKED) && own_valid && out_free;

  assign req_ready_out = ((state == LOCKED) && out_free) ? grant_out : '0;

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_out[i]) begin
        own_data = own_data | req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= IDX_W'(NUM_REQ - 1);
      burst_cnt    <= '0;
      idle_cnt     <= '0;
      grant_out    <= '0;
      valid_tx_out <= 1'b0;
      data_tx_out  <= '0;
      timeout_out  <= 1'b0;
    end else begin
      timeout_out <= 1'b0;

      if (own_accept) begin
        valid_tx_out <= 1'b1;
        data_tx_out  <= own_data;
      end else if (ready_tx_in) begin
        valid_tx_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req_valid_in) begin
            grant_out <= pick;
            rr_ptr    <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (own_accept) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
            idle_cnt  <= '0;
            if (own_last || (burst_cnt == BURST_W'(MAX_BURST - 1))) begin
              state <= DRAIN;
            end
          end else if (!own_valid) begin
            // Stalled owner: count up to the limit, then force the release.
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              state       <= DRAIN;
              timeout_out <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_free) begin
            grant_out <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (MAX_BURST=4, TIMEOUT_CYCLES=8)
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid_in;
  logic [NR*8-1:0] req_data_in;
  logic [NR-1:0]   req_last_in;
  logic [NR-1:0]   req_ready_out;
  logic            valid_tx_out;
  logic [7:0]      data_tx_out;
  logic            ready_tx_in;
  logic [NR-1:0]   grant_out;
  logic            timeout_out;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(8), .MAX_BURST(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_last_in   (req_last_in),
    .req_ready_out (req_ready_out),
    .valid_tx_out  (valid_tx_out),
    .data_tx_out   (data_tx_out),
    .ready_tx_in   (ready_tx_in),
    .grant_out     (grant_out),
    .timeout_out   (timeout_out)
  );

  always #5 clock = ~clock;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    exp_data_q[$];
  logic [NR-1:0] exp_grant_q[$];
  logic [8:0]    src_mem [NR][32];
  int            src_head [NR] = '{default: 0};
  int            src_tail [NR] = '{default: 0};
  logic [NR-1:0] prev_grant = '0;
  logic [NR-1:0] seen_grants = '0;
  int            pulse_cnt = 0;
  logic [7:0]    mon_data;
  logic [NR-1:0] mon_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic last);
    src_mem[r][src_tail[r]] = {last, d};
    src_tail[r]++;
  endtask

  function automatic bit busy();
    bit b;
    b = (grant_out != '0) || valid_tx_out || (exp_data_q.size() != 0) || (exp_grant_q.size() != 0);
    for (int i = 0; i < NR; i++) if (src_head[i] < src_tail[i]) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin @(negedge clock); n++; end
    if (n >= budget) fail_now("wait_idle");
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_grant(input logic [NR-1:0] g, input int budget);
    int n = 0;
    while (grant_out !== g && n < budget) begin @(negedge clock); n++; end
    if (n >= budget) fail_now("wait_grant");
  endtask

  task automatic wait_valid_tx(input int budget);
    int n = 0;
    while (!valid_tx_out && n < budget) begin @(negedge clock); n++; end
    if (n >= budget) fail_now("wait_valid_tx");
  endtask

  // Requester model: present the head of each source queue, pop it after a handshake.
  initial begin
    logic [NR-1:0] fire;
    req_valid_in = '0;
    req_last_in  = '0;
    req_data_in  = '0;
    forever begin
      @(negedge clock);
      fire = req_valid_in & req_ready_out;
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && !reset) src_head[i]++;
        if (src_head[i] < src_tail[i]) begin
          req_valid_in[i]        = 1'b1;
          req_last_in[i]         = src_mem[i][src_head[i]][8];
          req_data_in[i*8 +: 8]  = src_mem[i][src_head[i]][7:0];
        end else begin
          req_valid_in[i] = 1'b0;
          req_last_in[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every UART transfer and every new grant against the queues.
  always @(negedge clock) begin
    if (reset) begin
      prev_grant = '0;
    end else begin
      if (valid_tx_out && ready_tx_in) begin
        if (exp_data_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL uart_data: unexpected byte 0x%02h, expected none", data_tx_out);
        end else begin
          mon_data = exp_data_q.pop_front();
          check("uart_data", {24'd0, data_tx_out}, {24'd0, mon_data});
        end
      end
      if (grant_out != prev_grant && grant_out != '0) begin
        if (exp_grant_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL grant_seq: unexpected grant %b, expected none", grant_out);
        end else begin
          mon_grant = exp_grant_q.pop_front();
          check("grant_seq", {28'd0, grant_out}, {28'd0, mon_grant});
        end
      end
      prev_grant  = grant_out;
      seen_grants = seen_grants | grant_out;
      if (timeout_out) pulse_cnt++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int n;
    reset       = 1'b1;
    ready_tx_in = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, valid_tx_out}, 0);
    check("rst_data", {24'd0, data_tx_out}, 0);
    check("rst_grant", {28'd0, grant_out}, 0);
    check("rst_timeout", {31'd0, timeout_out}, 0);
    check("rst_ready", {28'd0, req_ready_out}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single owner, three-byte packet, back-to-back.
    load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
    exp_grant_q.push_back(4'b0001);
    exp_data_q.push_back(8'h11); exp_data_q.push_back(8'h22); exp_data_q.push_back(8'h33);
    n = 0;
    while (!req_valid_in[0] && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) fail_now("t1_req_valid");
    check("t1_grant_before", {28'd0, grant_out}, 0);
    @(negedge clock); check("t1_grant", {28'd0, grant_out}, 4'b0001);
    @(negedge clock); check("t1_byte0", {23'd0, valid_tx_out, data_tx_out}, {23'd0, 1'b1, 8'h11});
    @(negedge clock); check("t1_byte1", {23'd0, valid_tx_out, data_tx_out}, {23'd0, 1'b1, 8'h22});
    @(negedge clock); check("t1_byte2", {23'd0, valid_tx_out, data_tx_out}, {23'd0, 1'b1, 8'h33});
    @(negedge clock); check("t1_release", {28'd0, grant_out}, 0);
    wait_idle(100);

    // UART backpressure: 0xA5 must sit in the output register.
    ready_tx_in = 1'b0;
    load(1, 8'hA5, 1'b0); load(1, 8'h5A, 1'b1);
    exp_grant_q.push_back(4'b0010);
    exp_data_q.push_back(8'hA5); exp_data_q.push_back(8'h5A);
    wait_valid_tx(30);
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_valid", {31'd0, valid_tx_out}, 1);
      check("t3_stall_data", {24'd0, data_tx_out}, 8'hA5);
      check("t3_stall_ready", {28'd0, req_ready_out}, 0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    ready_tx_in = 1'b1;
    wait_idle(100);

    // Timeout: one byte, no last, owner goes quiet.
    pulse_cnt = 0;
    load(2, 8'h3C, 1'b0);
    exp_grant_q.push_back(4'b0100);
    exp_data_q.push_back(8'h3C);
    wait_valid_tx(30);
    n = 0;
    do begin @(negedge clock); n++; end while (!timeout_out && n < 40);
    check("t5_idle_cycles", n, 8);
    @(negedge clock);
    check("t5_pulse_width", {31'd0, timeout_out}, 0);
    check("t5_release", {28'd0, grant_out}, 0);
    wait_idle(100);
    check("t5_pulse_count", pulse_cnt, 1);

    // Fairness: req0 and req2 alternate single-byte packets.
    seen_grants = '0;
    load(0, 8'hA0, 1'b1); load(0, 8'hA1, 1'b1);
    load(2, 8'hB0, 1'b1); load(2, 8'hB1, 1'b1);
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0100);
    exp_data_q.push_back(8'hA0); exp_data_q.push_back(8'hB0);
    exp_data_q.push_back(8'hA1); exp_data_q.push_back(8'hB1);
    wait_idle(200);
    check("t2_seen_grants", {28'd0, seen_grants}, 4'b0101);

    // Burst cap of 4: req1 streams 10 bytes, req3 waits with one byte.
    for (int k = 0; k < 10; k++) load(1, 8'hD0 + 8'(k), 1'b0);
    exp_grant_q.push_back(4'b0010); exp_grant_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0010); exp_grant_q.push_back(4'b0010);
    for (int k = 0; k < 4; k++) exp_data_q.push_back(8'hD0 + 8'(k));
    exp_data_q.push_back(8'hC0);
    for (int k = 4; k < 10; k++) exp_data_q.push_back(8'hD0 + 8'(k));
    wait_grant(4'b0010, 30);
    load(3, 8'hC0, 1'b1);
    wait_idle(300);

    // Asynchronous reset with a byte stuck in the output register.
    ready_tx_in = 1'b0;
    load(0, 8'hE0, 1'b0); load(0, 8'hE1, 1'b0); load(0, 8'hE2, 1'b1);
    exp_grant_q.push_back(4'b0001);
    exp_data_q.push_back(8'hE0);
    wait_grant(4'b0001, 30);
    load(3, 8'hF0, 1'b1);
    wait_valid_tx(30);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, valid_tx_out}, 0);
    check("t6_rst_data", {24'd0, data_tx_out}, 0);
    check("t6_rst_grant", {28'd0, grant_out}, 0);
    check("t6_rst_timeout", {31'd0, timeout_out}, 0);
    check("t6_rst_ready", {28'd0, req_ready_out}, 0);
    exp_data_q.delete();
    exp_grant_q.delete();
    @(negedge clock);
    @(negedge clock);
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b1000);
    exp_data_q.push_back(8'hE1); exp_data_q.push_back(8'hE2); exp_data_q.push_back(8'hF0);
    reset       = 1'b0;
    ready_tx_in = 1'b1;
    wait_idle(200);

    check("end_data_q_empty", exp_data_q.size(), 0);
    check("end_grant_q_empty", exp_grant_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
